// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - start/busy/done operand and result bundle for serial_subtractor
interface serial_subtractor_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  // requester side: issues operands, observes status and result
  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout
  );

  // subtractor side: accepts operands, owns status and result
  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout
  );
endinterface

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a-b-bin subtractor, LSB first; SERIAL_SUB_SAT_EN clamps negative results to zero
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  serial_subtractor_if.slave sub
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic             borrow;
  logic [CW-1:0]    cnt;
  // completed result bits so far; the bit entering this cycle fills the MSB
  logic [WIDTH-2:0] work;

  logic             x;
  logic             y;
  logic             d;
  logic             nb;
  logic [WIDTH-1:0] next_work;
  logic [WIDTH-1:0] commit;

  // one full-subtractor cell on the current LSBs plus the result shift
  always_comb begin
    x         = sa[0];
    y         = sb[0];
    d         = x ^ y ^ borrow;
    nb        = (~x & y) | (~(x ^ y) & borrow);
    next_work = {d, work};
  end

  // value written to diff when the last bit completes
  always_comb begin
`ifdef SERIAL_SUB_SAT_EN
    commit = nb ? '0 : next_work;
`else
    commit = next_work;
`endif
  end

  // control FSM with registered status and result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sa       <= '0;
      sb       <= '0;
      borrow   <= 1'b0;
      cnt      <= '0;
      work     <= '0;
      sub.busy <= 1'b0;
      sub.done <= 1'b0;
      sub.diff <= '0;
      sub.bout <= 1'b0;
    end else begin
      sub.done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (sub.start) begin
            sa       <= sub.a;
            sb       <= sub.b;
            borrow   <= sub.bin;
            cnt      <= '0;
            work     <= '0;
            sub.busy <= 1'b1;
            state    <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          sa     <= sa >> 1;
          sb     <= sb >> 1;
          borrow <= nb;
          work   <= next_work[WIDTH-1:1];
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            sub.diff <= commit;
            sub.bout <= nb;
            sub.done <= 1'b1;
            sub.busy <= 1'b0;
            state    <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - randomized scoreboard bench for serial_subtractor
module tb_serial_subtractor;
  localparam int W = 4;

  typedef struct {
    logic [W-1:0] diff;
    logic         bout;
    int           cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   busy_run = 0;
  exp_t sb_q[$];

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .sub (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // arithmetic reference: plain integer subtraction, borrow = went negative
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic bin, input int done_cyc);
    exp_t e;
    int   full;
    full   = int'(a) - int'(b) - int'(bin);
    e.bout = (full < 0);
    e.diff = full[W-1:0];
`ifdef SERIAL_SUB_SAT_EN
    if (e.bout) e.diff = '0;
`endif
    e.cyc = done_cyc;
    return e;
  endfunction

  // monitor: compare every done pulse against the oldest expectation
  always @(negedge clk) begin
    if (rst) begin
      busy_run = 0;
    end else begin
      if (bus.busy) busy_run++;
      if (bus.done) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("diff", int'(bus.diff), int'(e.diff));
          check("bout", int'(bus.bout), int'(e.bout));
          check("latency", cyc, e.cyc);
          check("busy_cycles", busy_run, W);
        end
        busy_run = 0;
      end
    end
  end

  // waits at negedges until idle, scrambling inputs (incl. ignored start) meanwhile
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                       input bit expect_done, input bit noise);
    int n = 0;
    while (bus.busy) begin
      if (noise) begin
        bus.start = 1'($urandom_range(0, 1));
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        bus.bin   = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      n++;
      if (n > 100) begin
        check("idle_timeout", n, 0);
        return;
      end
    end
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.bin   = bin;
    if (expect_done) sb_q.push_back(model(a, b, bin, cyc + W + 1));
    @(negedge clk);
    bus.start = 1'b0;
    if (noise) begin
      bus.a   = W'($urandom);
      bus.b   = W'($urandom);
      bus.bin = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_left", sb_q.size(), 0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.bin   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_diff", int'(bus.diff), 0);
    check("rst_bout", int'(bus.bout), 0);
    rst = 1'b0;
    @(negedge clk);

    // directed corner cases
    issue(4'd9,  4'd3, 1'b0, 1'b1, 1'b0);
    drain();
    issue(4'd3,  4'd9, 1'b0, 1'b1, 1'b0);
    drain();
    issue(4'd0,  4'd0, 1'b1, 1'b1, 1'b0);
    drain();
    issue(4'd15, 4'd0, 1'b1, 1'b1, 1'b0);
    drain();

    // back-to-back equal operands
    for (int i = 0; i < 15; i++) issue(W'(i), W'(i), 1'b0, 1'b1, 1'b0);
    drain();

    // start re-pulsed mid-operation must be ignored
    issue(4'd12, 4'd5, 1'b0, 1'b1, 1'b0);
    bus.start = 1'b1;
    bus.a     = 4'd1;
    bus.b     = 4'd1;
    @(negedge clk);
    bus.start = 1'b0;
    drain();
    repeat (3) @(negedge clk);
    check("no_extra_done", int'(bus.done), 0);

    // reset in the middle of an operation
    issue(4'd7, 4'd2, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", int'(bus.busy), 0);
    check("midrst_done", int'(bus.done), 0);
    check("midrst_diff", int'(bus.diff), 0);
    check("midrst_bout", int'(bus.bout), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(4'd5, 4'd5, 1'b0, 1'b1, 1'b0);
    drain();

    // randomized operands with idle gaps and input noise while busy
    for (int k = 0; k < 60; k++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'b1, 1'b1);
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
    end
    bus.start = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
